seg7_capture4: RTL and testbench
================================

SEG7_CAPTURE4 -- requirements
Module: seg7_capture4

Interface
REQ-001 SHALL have parameter STABLE_CNT, default 4, number of consecutive identical samples required before a digit is captured (legal range 2..255).
REQ-002 SHALL have port iCLK, input, 1, sole clock; all state changes on its rising edge.
REQ-003 SHALL have port iRST, input, 1, reset, asynchronous, active-high.
REQ-004 SHALL have port iSEG, input, 7, active-low segment lines of a scanned 7-segment bus: bit0 top, bit1 upper-right, bit2 lower-right, bit3 bottom, bit4 lower-left, bit5 upper-left, bit6 middle.
REQ-005 SHALL have port iDIGSEL, input, 4, active-low digit select; bit k low selects digit k.
REQ-006 SHALL have port iCLR, input, 1, synchronous clear of oERR.
REQ-007 SHALL have port oDIG, output, 16, last complete captured frame; digit k in bits [4k+3:4k].
REQ-008 SHALL have port oBLANK, output, 4, bit k set when digit k of the last frame was all segments off.
REQ-009 SHALL have port oVALID, output, 1, one-cycle pulse when oDIG/oBLANK update.
REQ-010 SHALL have port oERR, output, 1, sticky error flag.

Function
REQ-011 SHALL form a sample pair {sel,seg} each cycle from iDIGSEL/iSEG (through the synchroniser when configured, REQ-027).
REQ-012 SHALL keep a run counter: reset to 1 when the sample pair differs from the previous cycle's pair, incremented (saturating at 255) when equal.
REQ-013 SHALL perform exactly one capture decision per stable run, on the edge where the run counter reaches STABLE_CNT; none while the run continues.
REQ-014 SHALL decode seg to nibble with the 16 patterns 0x0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110 (bit6..bit0).
REQ-015 SHALL treat seg=1111111 as blank: store nibble 0 and set the shadow blank bit for that digit.
REQ-016 SHALL at a capture decision with exactly one sel bit low and a decodable or blank pattern, write the nibble/blank bit into the shadow slot for that digit and set its seen bit; a re-capture of an already-seen digit overwrites the slot.
REQ-017 SHALL at a capture decision with sel=1111 (idle) do nothing.
REQ-018 SHALL at a capture decision with more than one sel bit low, or exactly one low with an undecodable pattern, set oERR and leave shadow and seen bits unchanged.
REQ-019 SHALL, on the edge where the seen bits become 1111, load oDIG and oBLANK from the shadow (including the digit captured on that edge), assert oVALID for that one cycle, and clear all seen bits.
REQ-020 SHALL hold oDIG and oBLANK stable between frame completions; oVALID low otherwise.
REQ-021 SHALL clear oERR on the edge after iCLR is sampled high, unless a new error is detected on the same edge, in which case oERR remains set.
REQ-022 SHALL produce the capture decision for a single-cycle or shorter-than-STABLE_CNT glitch never.

Reset
REQ-023 SHALL on iRST high asynchronously clear oDIG to 0x0000, oBLANK to 0000, oVALID to 0, oERR to 0.
REQ-024 SHALL on iRST high clear seen bits, shadow, synchroniser stages, previous-sample register to {1111,1111111}, and run counter to 0.
REQ-025 SHALL discard any partial frame when reset asserts mid-frame; the first frame after reset requires all four digits anew.
REQ-026 SHALL resume sampling on the first rising edge of iCLK after iRST deasserts.

Configuration
REQ-027 SHALL when SEG7_CAPTURE_SYNC_EN is defined pass iSEG and iDIGSEL through a two-flop synchroniser, adding exactly 2 cycles of latency; when undefined, sample them directly (inputs assumed synchronous to iCLK), with all other behaviour identical.

Verification
REQ-028 SHALL cover: STABLE_CNT=4, digits 0..3 driven with patterns 5,A,0,1 for 8 cycles each -> one oVALID pulse, oDIG=0x10A5, oBLANK=0000, oERR=0.
REQ-029 SHALL cover: digit 2 driven 1111111, others 3 -> oDIG=0x3033, oBLANK=0100.
REQ-030 SHALL cover: digit 1 seg=1010101 stable 8 cycles -> oERR=1, no oVALID until digit 1 later valid; iCLR pulse -> oERR=0 next cycle.
REQ-031 SHALL cover: 3-cycle glitch to pattern 8 on digit 0 between valid scans -> no capture of 8, oDIG unchanged from the valid values.
REQ-032 SHALL cover: iDIGSEL=1100 stable -> oERR=1; iRST pulse after three digits captured -> outputs zero, next complete four-digit scan yields one oVALID.
REQ-033 SHALL cover: both builds -> oVALID timing differs by exactly 2 cycles with SEG7_CAPTURE_SYNC_EN defined.

Source files
------------

// File: rtl/seg7_capture4.sv
// Captures four digits from a scanned, active-low 7-segment bus once each digit is stable.
// Optional two-flop input synchroniser enabled by defining SEG7_CAPTURE_SYNC_EN.
module seg7_capture4 #(
  parameter int STABLE_CNT = 4
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [6:0]  iSEG,
  input  logic [3:0]  iDIGSEL,
  input  logic        iCLR,
  output logic [15:0] oDIG,
  output logic [3:0]  oBLANK,
  output logic        oVALID,
  output logic        oERR
);

  localparam logic [10:0] IDLE_PAIR   = 11'h7FF;
  localparam logic [7:0]  DECIDE_PREV = 8'(STABLE_CNT - 1);

  // Result is {decodable, blank, nibble}; the all-off pattern counts as decodable.
  function automatic logic [5:0] seg7Decode(input logic [6:0] seg);
    logic [5:0] res;
    case (seg)
      7'b1000000: res = {1'b1, 1'b0, 4'h0};
      7'b1111001: res = {1'b1, 1'b0, 4'h1};
      7'b0100100: res = {1'b1, 1'b0, 4'h2};
      7'b0110000: res = {1'b1, 1'b0, 4'h3};
      7'b0011001: res = {1'b1, 1'b0, 4'h4};
      7'b0010010: res = {1'b1, 1'b0, 4'h5};
      7'b0000010: res = {1'b1, 1'b0, 4'h6};
      7'b1111000: res = {1'b1, 1'b0, 4'h7};
      7'b0000000: res = {1'b1, 1'b0, 4'h8};
      7'b0011000: res = {1'b1, 1'b0, 4'h9};
      7'b0001000: res = {1'b1, 1'b0, 4'hA};
      7'b0000011: res = {1'b1, 1'b0, 4'hB};
      7'b1000110: res = {1'b1, 1'b0, 4'hC};
      7'b0100001: res = {1'b1, 1'b0, 4'hD};
      7'b0000110: res = {1'b1, 1'b0, 4'hE};
      7'b0001110: res = {1'b1, 1'b0, 4'hF};
      7'b1111111: res = {1'b1, 1'b1, 4'h0};
      default:    res = {1'b0, 1'b0, 4'h0};
    endcase
    return res;
  endfunction

  logic [10:0] samplePair_s;

`ifdef SEG7_CAPTURE_SYNC_EN
  logic [10:0] sync1_r;
  logic [10:0] sync2_r;

  // Two-flop synchroniser for the asynchronous display bus.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      sync1_r <= IDLE_PAIR;
      sync2_r <= IDLE_PAIR;
    end else begin
      sync1_r <= {iDIGSEL, iSEG};
      sync2_r <= sync1_r;
    end
  end

  assign samplePair_s = sync2_r;
`else
  assign samplePair_s = {iDIGSEL, iSEG};
`endif

  logic [10:0] prevPair_r;
  logic [7:0]  runCnt_r;
  logic [3:0]  seen_r;
  logic [15:0] shadowDig_r;
  logic [3:0]  shadowBlank_r;

  logic [3:0]  sel_s;
  logic [5:0]  decoded_s;
  logic        same_s;
  logic        decide_s;
  logic        oneLow_s;
  logic        idle_s;
  logic [1:0]  digIdx_s;
  logic        capture_s;
  logic        err_s;
  logic [3:0]  seenNext_s;
  logic [15:0] shadowDigNext_s;
  logic [3:0]  shadowBlankNext_s;
  logic        frameDone_s;

  // Capture decision, select decode and next shadow/seen contents.
  always_comb begin
    sel_s             = samplePair_s[10:7];
    decoded_s         = seg7Decode(samplePair_s[6:0]);
    same_s            = (samplePair_s == prevPair_r);
    decide_s          = same_s && (runCnt_r == DECIDE_PREV);
    oneLow_s          = 1'b0;
    idle_s            = 1'b0;
    digIdx_s          = 2'd0;
    seenNext_s        = seen_r;
    shadowDigNext_s   = shadowDig_r;
    shadowBlankNext_s = shadowBlank_r;
    case (sel_s)
      4'b1110: begin oneLow_s = 1'b1; digIdx_s = 2'd0; end
      4'b1101: begin oneLow_s = 1'b1; digIdx_s = 2'd1; end
      4'b1011: begin oneLow_s = 1'b1; digIdx_s = 2'd2; end
      4'b0111: begin oneLow_s = 1'b1; digIdx_s = 2'd3; end
      4'b1111: idle_s = 1'b1;
      default: oneLow_s = 1'b0;
    endcase
    capture_s = decide_s && oneLow_s && decoded_s[5];
    err_s     = decide_s && !idle_s && !(oneLow_s && decoded_s[5]);
    if (capture_s) begin
      shadowDigNext_s[4*digIdx_s +: 4] = decoded_s[3:0];
      shadowBlankNext_s[digIdx_s]      = decoded_s[4];
      seenNext_s[digIdx_s]             = 1'b1;
    end else begin
      seenNext_s = seen_r;
    end
    frameDone_s = (seenNext_s == 4'b1111);
  end

  // Run tracking, shadow update, frame publication and sticky error.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      prevPair_r    <= IDLE_PAIR;
      runCnt_r      <= 8'd0;
      seen_r        <= 4'b0000;
      shadowDig_r   <= 16'h0000;
      shadowBlank_r <= 4'b0000;
      oDIG          <= 16'h0000;
      oBLANK        <= 4'b0000;
      oVALID        <= 1'b0;
      oERR          <= 1'b0;
    end else begin
      prevPair_r    <= samplePair_s;
      shadowDig_r   <= shadowDigNext_s;
      shadowBlank_r <= shadowBlankNext_s;
      if (!same_s) begin
        runCnt_r <= 8'd1;
      end else if (runCnt_r != 8'd255) begin
        runCnt_r <= runCnt_r + 8'd1;
      end else begin
        runCnt_r <= runCnt_r;
      end
      if (frameDone_s) begin
        oDIG   <= shadowDigNext_s;
        oBLANK <= shadowBlankNext_s;
        oVALID <= 1'b1;
        seen_r <= 4'b0000;
      end else begin
        oVALID <= 1'b0;
        seen_r <= seenNext_s;
      end
      // A fresh error wins over a simultaneous clear.
      if (err_s) begin
        oERR <= 1'b1;
      end else if (iCLR) begin
        oERR <= 1'b0;
      end else begin
        oERR <= oERR;
      end
    end
  end

endmodule

// File: tb/tb_seg7_capture4.sv
// Directed bench for seg7_capture4 with STABLE_CNT=4; adapts frame timing to SEG7_CAPTURE_SYNC_EN.
module tb_seg7_capture4;

`ifdef SEG7_CAPTURE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  localparam logic [6:0] P0 = 7'b1000000;
  localparam logic [6:0] P1 = 7'b1111001;
  localparam logic [6:0] P3 = 7'b0110000;
  localparam logic [6:0] P5 = 7'b0010010;
  localparam logic [6:0] P8 = 7'b0000000;
  localparam logic [6:0] PA = 7'b0001000;
  localparam logic [6:0] PBAD = 7'b1010101;
  localparam logic [6:0] PBLANK = 7'b1111111;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic [6:0]  iSEG = 7'b1111111;
  logic [3:0]  iDIGSEL = 4'b1111;
  logic        iCLR = 1'b0;
  logic [15:0] oDIG;
  logic [3:0]  oBLANK;
  logic        oVALID;
  logic        oERR;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int validCnt = 0;
  int lastValidCyc = -1;
  int c0 = 0;

  seg7_capture4 #(.STABLE_CNT(4)) dut (
    .iCLK(iCLK), .iRST(iRST), .iSEG(iSEG), .iDIGSEL(iDIGSEL), .iCLR(iCLR),
    .oDIG(oDIG), .oBLANK(oBLANK), .oVALID(oVALID), .oERR(oERR)
  );

  always #5 iCLK = ~iCLK;

  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [3:0] sel, input logic [6:0] seg, input int n);
    iDIGSEL = sel;
    iSEG = seg;
    repeat (n) begin
      @(posedge iCLK);
      #1;
      if (oVALID) begin
        validCnt++;
        lastValidCyc = cyc;
      end
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge iCLK);
    #1;
    check("rst_dig", 32'(oDIG), 32'h0000);
    check("rst_blank", 32'(oBLANK), 32'h0);
    check("rst_valid", 32'(oVALID), 32'h0);
    check("rst_err", 32'(oERR), 32'h0);
    iRST = 1'b0;
    hold(4'b1111, PBLANK, 3);

    // Basic frame 5,A,0,1
    validCnt = 0;
    c0 = cyc;
    hold(4'b1110, P5, 8);
    hold(4'b1101, PA, 8);
    hold(4'b1011, P0, 8);
    hold(4'b0111, P1, 8);
    hold(4'b1111, PBLANK, 6);
    check("t1_vcnt", 32'(validCnt), 32'd1);
    check("t1_time", 32'(lastValidCyc), 32'(c0 + 28 + LAT));
    check("t1_dig", 32'(oDIG), 32'h10A5);
    check("t1_blank", 32'(oBLANK), 32'h0);
    check("t1_err", 32'(oERR), 32'h0);

    // Blank digit 2
    validCnt = 0;
    hold(4'b1110, P3, 8);
    hold(4'b1101, P3, 8);
    hold(4'b1011, PBLANK, 8);
    hold(4'b0111, P3, 8);
    hold(4'b1111, PBLANK, 6);
    check("t2_vcnt", 32'(validCnt), 32'd1);
    check("t2_dig", 32'(oDIG), 32'h3033);
    check("t2_blank", 32'(oBLANK), 32'h4);

    // Undecodable pattern on digit 1, frame completes only once digit 1 is valid
    validCnt = 0;
    hold(4'b1110, P3, 8);
    hold(4'b1101, PBAD, 8);
    hold(4'b1011, P3, 8);
    hold(4'b0111, P3, 8);
    hold(4'b1111, PBLANK, 6);
    check("t3_err_set", 32'(oERR), 32'h1);
    check("t3_novalid", 32'(validCnt), 32'd0);
    check("t3_dig_hold", 32'(oDIG), 32'h3033);
    hold(4'b1101, P3, 8);
    hold(4'b1111, PBLANK, 6);
    check("t3_vcnt", 32'(validCnt), 32'd1);
    check("t3_dig", 32'(oDIG), 32'h3333);
    check("t3_blank", 32'(oBLANK), 32'h0);
    check("t3_err_before_clr", 32'(oERR), 32'h1);
    iCLR = 1'b1;
    @(posedge iCLK);
    #1;
    iCLR = 1'b0;
    check("t3_err_clr", 32'(oERR), 32'h0);

    // Short glitch to 8 on digit 0 must not be captured
    validCnt = 0;
    hold(4'b1110, P5, 8);
    hold(4'b1110, P8, 3);
    hold(4'b1101, PA, 8);
    hold(4'b1011, P0, 8);
    hold(4'b0111, P1, 8);
    hold(4'b1111, PBLANK, 6);
    check("t4_vcnt", 32'(validCnt), 32'd1);
    check("t4_dig", 32'(oDIG), 32'h10A5);
    check("t4_err", 32'(oERR), 32'h0);

    // Two digits selected, then reset mid-frame
    hold(4'b1100, P3, 8);
    hold(4'b1111, PBLANK, 6);
    check("t5_err_multi", 32'(oERR), 32'h1);
    validCnt = 0;
    hold(4'b1110, P1, 8);
    hold(4'b1101, P3, 8);
    hold(4'b1011, P5, 8);
    hold(4'b1111, PBLANK, 2);
    iRST = 1'b1;
    #1;
    check("t5_rst_dig", 32'(oDIG), 32'h0000);
    check("t5_rst_blank", 32'(oBLANK), 32'h0);
    check("t5_rst_valid", 32'(oVALID), 32'h0);
    check("t5_rst_err", 32'(oERR), 32'h0);
    @(posedge iCLK);
    #1;
    iRST = 1'b0;
    hold(4'b0111, PA, 8);
    hold(4'b1111, PBLANK, 6);
    check("t5_partial_discarded", 32'(validCnt), 32'd0);
    check("t5_dig_zero", 32'(oDIG), 32'h0000);
    hold(4'b1110, P1, 8);
    hold(4'b1101, P3, 8);
    hold(4'b1011, P5, 8);
    hold(4'b0111, PA, 8);
    hold(4'b1111, PBLANK, 6);
    check("t5_vcnt", 32'(validCnt), 32'd1);
    check("t5_dig", 32'(oDIG), 32'hA531);
    check("t5_err", 32'(oERR), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
